// File: rtl/m68k_bus_master.sv
// m68k_bus_master: queued request front end driving a 68000-style asynchronous bus.
// Requests (REQ_*) are held in a small FIFO. The head entry is run through the S0..S7
// bus cycle. Progress is paced by edges of the sampled M68K_CLK.
// Ports:
//   CLK, RESET_n          system clock, async active-low reset
//   M68K_CLK              bus clock, sampled as data
//   REQ_*                 request handshake (valid/ready), rw/size/address/write data
//   RSP_*                 one-CLK completion pulse, read data, error flag
//   M68K_*                bus address/data/strobes, terminations, 6800 VMA/E
module m68k_bus_master #(
   parameter int unsigned ADDR_W      = 24,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned TIMEOUT_CYC = 256
) (
   input  logic              CLK,
   input  logic              RESET_n,
   input  logic              M68K_CLK,
   input  logic              REQ_VALID,
   output logic              REQ_READY,
   input  logic              REQ_RW,
   input  logic              REQ_SZ,
   input  logic [ADDR_W-1:0] REQ_A,
   input  logic [DATA_W-1:0] REQ_WD,
   output logic              RSP_VALID,
   output logic [DATA_W-1:0] RSP_RD,
   output logic              RSP_ERR,
   output logic [ADDR_W-2:0] M68K_A,
   input  logic [DATA_W-1:0] M68K_D_IN,
   output logic [DATA_W-1:0] M68K_D_OUT,
   output logic              M68K_D_OE,
   output logic              M68K_AS_n,
   output logic              M68K_UDS_n,
   output logic              M68K_LDS_n,
   output logic              M68K_RW,
   input  logic              M68K_DTACK_n,
   input  logic              M68K_BERR_n,
   input  logic              M68K_VPA_n,
   output logic              M68K_VMA_n,
   output logic              M68K_E
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned ToW  = $clog2(TIMEOUT_CYC + 1);

   typedef struct packed {
      logic              rw;
      logic              sz;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] wd;
   } req_t;

   typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} state_e;

   // Synchronisers; mclk_prev_q holds the previous synchronised bus clock for edge detect.
   logic [1:0] mclk_sync_q, dtack_sync_q, berr_sync_q, vpa_sync_q;
   logic       mclk_prev_q;

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         mclk_sync_q  <= 2'b00;
         dtack_sync_q <= 2'b11;
         berr_sync_q  <= 2'b11;
         vpa_sync_q   <= 2'b11;
         mclk_prev_q  <= 1'b0;
      end else begin
         mclk_sync_q  <= {mclk_sync_q[0], M68K_CLK};
         dtack_sync_q <= {dtack_sync_q[0], M68K_DTACK_n};
         berr_sync_q  <= {berr_sync_q[0], M68K_BERR_n};
         vpa_sync_q   <= {vpa_sync_q[0], M68K_VPA_n};
         mclk_prev_q  <= mclk_sync_q[1];
      end
   end

   logic r_ev, f_ev, dtack_n_s, berr_n_s, vpa_n_s;
   assign r_ev      = mclk_sync_q[1] & ~mclk_prev_q;
   assign f_ev      = ~mclk_sync_q[1] & mclk_prev_q;
   assign dtack_n_s = dtack_sync_q[1];
   assign berr_n_s  = berr_sync_q[1];
   assign vpa_n_s   = vpa_sync_q[1];

   // Request FIFO; storage has no reset, only pointers and occupancy do.
   req_t            fifo_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            push, pop;
   req_t            head;

   state_e              state_q, state_d;
   logic [3:0]          e_cnt_q, e_cnt_d;
   logic [ToW-1:0]      to_cnt_q, to_cnt_d;
   logic                vma_n_q, vma_n_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   rd_q, rd_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_err_q, rsp_err_d;

   assign REQ_READY = (count_q != CntW'(FIFO_DEPTH));
   assign push      = REQ_VALID & REQ_READY;
   assign pop       = (state_q == S7) & r_ev;
   assign head      = fifo_q[rd_ptr_q];

   always_ff @(posedge CLK) begin
      if (push) fifo_q[wr_ptr_q] <= '{rw: REQ_RW, sz: REQ_SZ, a: REQ_A, wd: REQ_WD};
   end

   logic term_ok, term_err, term;
   always_comb begin
      // A VPA-terminated cycle completes when VMA is already low and E is about to fall.
      term_err = ~berr_n_s | (to_cnt_q == ToW'(TIMEOUT_CYC));
      term_ok  = ~dtack_n_s | (~vma_n_q & (e_cnt_q == 4'd8));
      term     = ~berr_n_s | term_ok | term_err;

      wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      count_d  = count_q + CntW'(push) - CntW'(pop);

      e_cnt_d = e_cnt_q;
      if (f_ev) e_cnt_d = (e_cnt_q == 4'd9) ? 4'd0 : e_cnt_q + 4'd1;

      state_d     = state_q;
      to_cnt_d    = to_cnt_q;
      vma_n_d     = vma_n_q;
      err_d       = err_q;
      rd_d        = rd_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;

      unique case (state_q)
         S0: if (f_ev && count_q != '0) begin
            state_d  = S1;
            to_cnt_d = '0;
         end
         S1: if (r_ev) state_d = S2;
         S2: if (f_ev) state_d = S3;
         S3: if (r_ev) begin
            if (term) begin
               state_d = S4;
               // DTACK or a VPA handshake wins over a timeout reached on the same edge.
               err_d   = ~berr_n_s | (~term_ok & term_err);
            end else begin
               if (to_cnt_q != ToW'(TIMEOUT_CYC)) to_cnt_d = to_cnt_q + ToW'(1);
               if (!vpa_n_s && e_cnt_q == 4'd2) vma_n_d = 1'b0;
            end
         end
         S4: if (r_ev) state_d = S4; else if (f_ev) state_d = S5;
         S5: if (r_ev) state_d = S6;
         S6: if (f_ev) begin
            state_d = S7;
            if (head.rw) rd_d = M68K_D_IN;
         end
         S7: if (r_ev) begin
            state_d     = S0;
            vma_n_d     = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_q;
         end
         default: state_d = S0;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= S0;
         e_cnt_q     <= 4'd0;
         to_cnt_q    <= '0;
         vma_n_q     <= 1'b1;
         err_q       <= 1'b0;
         rd_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         e_cnt_q     <= e_cnt_d;
         to_cnt_q    <= to_cnt_d;
         vma_n_q     <= vma_n_d;
         err_q       <= err_d;
         rd_q        <= rd_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Bus outputs decode straight from the state register so reset releases them at once.
   logic as_win, ds_win, wr_win, a_win;
   always_comb begin
      as_win = (state_q >= S2) && (state_q <= S6);
      ds_win = head.rw ? as_win : ((state_q >= S3) && (state_q <= S6));
      wr_win = ~head.rw && (state_q >= S2);
      a_win  = (state_q != S0);

      M68K_AS_n  = ~as_win;
      M68K_UDS_n = ~(ds_win & (~head.sz | ~head.a[0]));
      M68K_LDS_n = ~(ds_win & (~head.sz | head.a[0]));
      M68K_RW    = ~wr_win;
      M68K_D_OE  = wr_win;
      M68K_D_OUT = head.wd;
      M68K_A     = a_win ? head.a[ADDR_W-1:1] : '0;
   end

   assign M68K_VMA_n = vma_n_q;
   assign M68K_E     = (e_cnt_q > 4'd5);
   assign RSP_VALID  = rsp_valid_q;
   assign RSP_RD     = rd_q;
   assign RSP_ERR    = rsp_err_q;

endmodule
